// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter: edge-captures NSRC request lines into pending
// bits, picks the highest-index eligible source, runs the drain/entry
// handshake with the hazard unit and holds in-service until ERET.

// Per-source cell: edge detector plus pending bit (set beats clear).
module exc_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pending
);
  logic src_q, src_d;
  logic pending_q, pending_d;

  // Next pending bit: a rising edge sets it, an entry on this source clears it.
  always_comb begin
    src_d     = src;
    pending_d = (pending_q & ~clr) | (src & ~src_q);
  end

  // src_q tracks the line even in reset so a level already high at release
  // does not register as a fresh request.
  always_ff @(posedge clk) begin
    src_q <= src_d;
    if (!reset) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;
endmodule

module exc_arbiter #(
  parameter int NSRC = 3,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_in,
  input  logic [NSRC-1:0] src_mask,
  input  logic            global_en,
  input  logic            exc_ack,
  input  logic            eret,
  output logic            exc_req,
  output logic            exc_take,
  output logic [CW-1:0]   cause,
  output logic            in_service,
  output logic [NSRC-1:0] pending
);

  // Cause is index+1 with 0 reserved for "none", so every index must fit.
  if (NSRC < 1 || NSRC > 8 || (1 << CW) <= NSRC) begin : g_bad_param
    $error("exc_arbiter: need 1<=NSRC<=8 and 2**CW > NSRC");
  end

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   win_idx_q, win_idx_d;
  logic [NSRC-1:0] elig, clr;
  logic [CW-1:0]   win;
  logic            mask_win, withdraw, take;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    exc_src_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .src     (src_in[i]),
      .clr     (clr[i]),
      .pending (pending[i])
    );
  end

  // Highest eligible index wins; later loop iterations override earlier ones.
  always_comb begin
    elig = pending & ~src_mask;
    win  = '0;
    for (int i = 0; i < NSRC; i++)
      if (elig[i]) win = CW'(i);
  end

  // Handshake decode and next state. Withdraw beats ack; the latched winner
  // is never replaced while in REQ. Entry is suppressed while reset is low.
  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    mask_win  = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (win_idx_q == CW'(i)) mask_win = src_mask[i];
    withdraw  = mask_win | ~global_en;
    take      = reset & (state_q == REQ) & exc_ack & ~withdraw;
    clr       = '0;
    for (int i = 0; i < NSRC; i++)
      if (win_idx_q == CW'(i)) clr[i] = take;
    case (state_q)
      IDLE: if (global_en && |elig) begin
        state_d   = REQ;
        win_idx_d = win;
      end
      REQ: begin
        if (withdraw)     state_d = IDLE;
        else if (exc_ack) state_d = SERVICE;
      end
      SERVICE: if (eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and winner registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      win_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
    end
  end

  assign exc_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign exc_take   = take;
  assign cause      = (state_q == IDLE) ? '0 : win_idx_q + CW'(1);

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_exc_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src_in, src_mask;
  logic       global_en, exc_ack, eret;
  logic       exc_req, exc_take, in_service;
  logic [2:0] cause, pending;

  int n_cmp = 0;
  int n_bad = 0;
  int take_cnt = 0;
  int t0;

  exc_arbiter #(.NSRC(3), .CW(3)) dut (
    .clk(clk), .reset(reset), .src_in(src_in), .src_mask(src_mask),
    .global_en(global_en), .exc_ack(exc_ack), .eret(eret),
    .exc_req(exc_req), .exc_take(exc_take), .cause(cause),
    .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (exc_take === 1'b1) take_cnt++;

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; src_in = 3'b111; src_mask = '0; global_en = 1'b1;
    exc_ack = 1'b0; eret = 1'b0;
    adv(); adv();
    @(negedge clk);
    n_cmp++; if (pending !== 3'b000) begin n_bad++; $display("FAIL rst_pending got %b want 000", pending); end
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL rst_exc_req got %b want 0", exc_req); end
    n_cmp++; if (cause !== 3'd0) begin n_bad++; $display("FAIL rst_cause got %0d want 0", cause); end
    adv(); reset = 1'b1;
    adv();
    @(negedge clk);
    n_cmp++; if (pending !== 3'b000) begin n_bad++; $display("FAIL rst_release_pending got %b want 000", pending); end
    adv();
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL rst_release_req got %b want 0", exc_req); end
    adv(); src_in = 3'b000;
    adv();
  endtask

  task automatic test_single();
    t0 = take_cnt;
    src_in = 3'b010;
    adv(); src_in = 3'b000;
    @(negedge clk);
    n_cmp++; if (pending !== 3'b010 || exc_req !== 1'b0) begin n_bad++; $display("FAIL single_pend got %b/%b want 010/0", pending, exc_req); end
    adv();
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b1 || cause !== 3'd2) begin n_bad++; $display("FAIL single_req got %b/%0d want 1/2", exc_req, cause); end
    n_cmp++; if (exc_take !== 1'b0) begin n_bad++; $display("FAIL single_notake got %b want 0", exc_take); end
    adv(); exc_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (exc_take !== 1'b1) begin n_bad++; $display("FAIL single_take got %b want 1", exc_take); end
    adv(); exc_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_service !== 1'b1 || exc_req !== 1'b0 || pending !== 3'b000 || cause !== 3'd2 || exc_take !== 1'b0)
      begin n_bad++; $display("FAIL single_service got svc=%b req=%b pend=%b cause=%0d take=%b want 1/0/000/2/0", in_service, exc_req, pending, cause, exc_take); end
    adv(); eret = 1'b1;
    adv(); eret = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_service !== 1'b0 || cause !== 3'd0) begin n_bad++; $display("FAIL single_eret got svc=%b cause=%0d want 0/0", in_service, cause); end
    n_cmp++; if (take_cnt - t0 !== 1) begin n_bad++; $display("FAIL single_takecnt got %0d want 1", take_cnt - t0); end
    adv();
  endtask

  task automatic test_priority();
    t0 = take_cnt;
    src_in = 3'b101;
    adv(); src_in = 3'b000;
    adv();
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b1 || cause !== 3'd3) begin n_bad++; $display("FAIL prio_first got %b/%0d want 1/3", exc_req, cause); end
    adv(); exc_ack = 1'b1;
    adv(); exc_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (pending !== 3'b001 || in_service !== 1'b1) begin n_bad++; $display("FAIL prio_svc got %b/%b want 001/1", pending, in_service); end
    adv(); eret = 1'b1;
    adv(); eret = 1'b0;
    @(negedge clk);
    n_cmp++; if (cause !== 3'd0 || exc_req !== 1'b0) begin n_bad++; $display("FAIL prio_idle got %0d/%b want 0/0", cause, exc_req); end
    adv();
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b1 || cause !== 3'd1) begin n_bad++; $display("FAIL prio_second got %b/%0d want 1/1", exc_req, cause); end
    adv(); exc_ack = 1'b1;
    adv(); exc_ack = 1'b0; eret = 1'b1;
    adv(); eret = 1'b0;
    n_cmp++; if (take_cnt - t0 !== 2) begin n_bad++; $display("FAIL prio_takecnt got %0d want 2", take_cnt - t0); end
    adv();
  endtask

  task automatic test_withdraw_and_service();
    t0 = take_cnt;
    src_in = 3'b100;
    adv(); src_in = 3'b000;
    adv(); src_mask = 3'b100; exc_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (exc_take !== 1'b0) begin n_bad++; $display("FAIL wd_notake got %b want 0", exc_take); end
    adv(); exc_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b0 || pending !== 3'b100 || cause !== 3'd0) begin n_bad++; $display("FAIL wd_idle got req=%b pend=%b cause=%0d want 0/100/0", exc_req, pending, cause); end
    adv(); src_mask = 3'b000;
    adv();
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b1 || cause !== 3'd3) begin n_bad++; $display("FAIL wd_rereq got %b/%0d want 1/3", exc_req, cause); end
    adv(); exc_ack = 1'b1;
    adv(); exc_ack = 1'b0;
    // in SERVICE: a new request must stay pending, no nesting
    src_in = 3'b100;
    adv(); src_in = 3'b000;
    @(negedge clk);
    n_cmp++; if (in_service !== 1'b1 || exc_req !== 1'b0 || pending !== 3'b100) begin n_bad++; $display("FAIL svc_hold got svc=%b req=%b pend=%b want 1/0/100", in_service, exc_req, pending); end
    adv(); adv(); eret = 1'b1;
    adv(); eret = 1'b0;
    adv();
    @(negedge clk);
    n_cmp++; if (exc_req !== 1'b1 || cause !== 3'd3) begin n_bad++; $display("FAIL svc_next got %b/%0d want 1/3", exc_req, cause); end
    adv(); exc_ack = 1'b1;
    adv(); exc_ack = 1'b0; eret = 1'b1;
    adv(); eret = 1'b0;
    adv(); eret = 1'b1;
    adv(); eret = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_service !== 1'b0 || exc_req !== 1'b0 || cause !== 3'd0) begin n_bad++; $display("FAIL idle_eret got svc=%b req=%b cause=%0d want 0/0/0", in_service, exc_req, cause); end
    n_cmp++; if (take_cnt - t0 !== 2) begin n_bad++; $display("FAIL wd_takecnt got %0d want 2", take_cnt - t0); end
    adv();
  endtask

  task automatic test_reset_in_service();
    src_in = 3'b010;
    adv(); src_in = 3'b000;
    adv(); exc_ack = 1'b1;
    adv(); exc_ack = 1'b0; src_in = 3'b001;
    adv(); src_in = 3'b000;
    @(negedge clk);
    n_cmp++; if (in_service !== 1'b1 || pending !== 3'b001) begin n_bad++; $display("FAIL rsvc_pre got %b/%b want 1/001", in_service, pending); end
    t0 = take_cnt;
    adv(); reset = 1'b0; exc_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (exc_take !== 1'b0) begin n_bad++; $display("FAIL rsvc_take_during got %b want 0", exc_take); end
    adv(); reset = 1'b1; exc_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_service !== 1'b0 || cause !== 3'd0 || pending !== 3'b000) begin n_bad++; $display("FAIL rsvc_post got svc=%b cause=%0d pend=%b want 0/0/000", in_service, cause, pending); end
    adv(); adv(); adv();
    n_cmp++; if (take_cnt - t0 !== 0) begin n_bad++; $display("FAIL rsvc_takecnt got %0d want 0", take_cnt - t0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_withdraw_and_service();
    test_reset_in_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
